// File: rtl/edge_bitmap_packer.sv
// edge_bitmap_packer
// Packs a raster-ordered 1-bit edge stream into bytes, LSB first. A partial
// byte at the end of a line is zero padded. Each byte is tagged with
// end-of-line/end-of-frame flags, queued in a first-word-fall-through FIFO,
// and leaves on a valid/ready handshake.
module edge_bitmap_packer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          pixel_valid,
  input  logic                          pixel_in,
  output logic [7:0]                    byte_data,
  output logic                          byte_eol,
  output logic                          byte_eof,
  output logic                          byte_valid,
  input  logic                          byte_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_done
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_HEIGHT - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(FIFO_DEPTH);

  // Position and packing state
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [2:0]    slot_q, slot_d;
  logic [6:0]    shreg_q, shreg_d;

  // FIFO state
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          frame_done_q, frame_done_d;

  // Combinational helpers
  logic          line_end_s;
  logic          frame_end_s;
  logic          push_s;
  logic [7:0]    pack_byte_s;
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          wr_en_s;
  logic          drop_s;
  logic [9:0]    head_s;

  // Column/row tracking and bit collection; a byte closes at slot 7 or line end
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    slot_d      = slot_q;
    shreg_d     = shreg_q;
    line_end_s  = (col_q == COL_LAST);
    frame_end_s = line_end_s && (row_q == ROW_LAST);
    push_s      = pixel_valid && ((slot_q == 3'd7) || line_end_s);
    // Collected bits occupy slots below slot_q (upper bits are kept zero),
    // the live pixel lands in slot_q.
    pack_byte_s          = {1'b0, shreg_q};
    pack_byte_s[slot_q]  = pixel_in;
    if (pixel_valid) begin
      if (line_end_s) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
      if (push_s) begin
        slot_d  = 3'd0;
        shreg_d = 7'd0;
      end else begin
        slot_d          = slot_q + 3'd1;
        shreg_d[slot_q] = pixel_in;
      end
    end else begin
      col_d = col_q;
    end
  end

  // FIFO bookkeeping: a push into a full FIFO survives only alongside a pop
  always_comb begin
    empty_s      = (level_q == '0);
    full_s       = (level_q == LEVEL_FULL);
    pop_s        = !empty_s && byte_ready;
    wr_en_s      = push_s && (!full_s || pop_s);
    drop_s       = push_s && full_s && !pop_s;
    wr_ptr_d     = wr_en_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d     = pop_s   ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    overflow_d   = overflow_q | drop_s;
    // Pulses for the eof byte whether it was stored or dropped
    frame_done_d = push_s && frame_end_s;
    case ({wr_en_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      slot_q       <= 3'd0;
      shreg_q      <= 7'd0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      slot_q       <= slot_d;
      shreg_q      <= shreg_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // FIFO storage; contents are meaningless once the pointers are reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= {frame_end_s, line_end_s, pack_byte_s};
    end
  end

  // Head entry is masked while empty so outputs read zero after reset
  always_comb begin
    head_s = empty_s ? 10'd0 : mem_q[rd_ptr_q];
  end

  assign byte_data  = head_s[7:0];
  assign byte_eol   = head_s[8];
  assign byte_eof   = head_s[9];
  assign byte_valid = !empty_s;
  assign fifo_level = level_q;
  assign overflow   = overflow_q;
  assign frame_done = frame_done_q;

endmodule
